// File: rtl/scratchpad_pkg.sv
// rtl/scratchpad_pkg.sv - shared types and constants for the scratchpad responder
//   state_t   : responder FSM states
//   POISON    : read data returned for out-of-range addresses
//   ERR_OOB   : err bit index for out-of-range accesses
//   ERR_PROTO : err bit index for protocol violations
//   READY_ONE : value driven on read_ready/write_ready while pulsing
//   SIZE_WORD : the only legal request size
package scratchpad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_WAIT,
        WR_RESP
    } state_t;

    localparam logic [31:0] POISON    = 32'hDEAD_BEEF;
    localparam int          ERR_OOB   = 0;
    localparam int          ERR_PROTO = 1;
    localparam logic [63:0] READY_ONE = 64'd1;
    localparam logic [63:0] SIZE_WORD = 64'd4;

endpackage

// File: rtl/scratchpad_ram.sv
// rtl/scratchpad_ram.sv - 1R1W synchronous write-first RAM, no reset
//   mod_clk : clock
//   we      : write enable
//   waddr   : write word index
//   wdata   : write data
//   raddr   : read word index, sampled every clock
//   rdata   : registered read data (shows wdata when reading the word being written)
module scratchpad_ram #(
    parameter int AW = 12
) (
    input  logic          mod_clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge mod_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/scratchpad_responder.sv
// rtl/scratchpad_responder.sv - fixed-latency 32-bit scratchpad read/write responder
//   mod_clk, reset                  : clock, async active-high reset
//   read_enable/addr/size           : read request (one-cycle strobe)
//   write_enable/addr/data/size     : write request (one-cycle strobe)
//   read_ready, read_data           : one-cycle read response, data held afterwards
//   write_ready                     : one-cycle write commit pulse
//   err                             : sticky [0] out-of-range, [1] protocol
//   rd_count, wr_count              : saturating completion counters, only with
//                                     SCRATCHPAD_RESP_STATS_EN defined
module scratchpad_responder
    import scratchpad_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR  = 64'h0,
    parameter int          DEPTH_LOG2 = 12,
    parameter int          RD_LAT     = 2,
    parameter int          WR_LAT     = 1
) (
    input  logic        mod_clk,
    input  logic        reset,
    input  logic        read_enable,
    input  logic [63:0] read_addr,
    input  logic [63:0] read_size,
    input  logic        write_enable,
    input  logic [63:0] write_addr,
    input  logic [31:0] write_data,
    input  logic [63:0] write_size,
    output logic [63:0] read_ready,
    output logic [31:0] read_data,
    output logic [63:0] write_ready,
    output logic [1:0]  err
`ifdef SCRATCHPAD_RESP_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam logic [3:0] RD_CNT = 4'(RD_LAT - 1);
    localparam logic [3:0] WR_CNT = 4'(WR_LAT - 1);

    state_t                state;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] rd_idx_q, wr_idx_q;
    logic                  rd_oob_q, wr_oob_q, rd_pend_q;
    logic [31:0]           wr_data_q, rd_hold, ram_q;

    logic [63:0]           rd_off, wr_off;
    logic [DEPTH_LOG2-1:0] rd_in_idx, wr_in_idx;
    logic                  rd_in_oob, wr_in_oob;
    logic                  in_idle, wr_commit, ram_we;
    logic [DEPTH_LOG2-1:0] ram_waddr, ram_raddr;
    logic [31:0]           ram_wdata;

    assign rd_off    = read_addr - BASE_ADDR;
    assign wr_off    = write_addr - BASE_ADDR;
    assign rd_in_oob = (read_addr < BASE_ADDR) || ((rd_off >> (DEPTH_LOG2 + 2)) != 64'd0);
    assign wr_in_oob = (write_addr < BASE_ADDR) || ((wr_off >> (DEPTH_LOG2 + 2)) != 64'd0);
    assign rd_in_idx = rd_off[DEPTH_LOG2+1:2];
    assign wr_in_idx = wr_off[DEPTH_LOG2+1:2];

    assign in_idle = (state == IDLE);

    // The memory write lands on the same edge that enters WR_RESP, so a
    // following read (including the pending one) always sees the new data.
    assign wr_commit = (in_idle && write_enable && (WR_LAT == 1)) ||
                       ((state == WR_WAIT) && (cnt == 4'd1));
    assign ram_we    = wr_commit && !(in_idle ? wr_in_oob : wr_oob_q);
    assign ram_waddr = in_idle ? wr_in_idx : wr_idx_q;
    assign ram_wdata = in_idle ? write_data : wr_data_q;

    // RAM samples every edge; in IDLE the live address feeds it so that a
    // single-cycle read has its data ready in RD_RESP.
    assign ram_raddr = in_idle ? rd_in_idx : rd_idx_q;

    assign read_data = (state == RD_RESP) ? (rd_oob_q ? POISON : ram_q) : rd_hold;

    scratchpad_ram #(.AW(DEPTH_LOG2)) u_ram (
        .mod_clk (mod_clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr   (ram_raddr),
        .rdata   (ram_q)
    );

    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            read_ready  <= '0;
            write_ready <= '0;
            rd_hold     <= '0;
            err         <= '0;
            rd_idx_q    <= '0;
            wr_idx_q    <= '0;
            rd_oob_q    <= 1'b0;
            wr_oob_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            wr_data_q   <= '0;
        end else begin
            read_ready  <= '0;
            write_ready <= '0;
            if (!in_idle && (read_enable || write_enable)) begin
                err[ERR_PROTO] <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (write_enable) begin
                        wr_idx_q  <= wr_in_idx;
                        wr_oob_q  <= wr_in_oob;
                        wr_data_q <= write_data;
                        // A simultaneous read is parked and served after WR_RESP.
                        rd_pend_q <= read_enable;
                        rd_idx_q  <= rd_in_idx;
                        rd_oob_q  <= rd_in_oob;
                        if (wr_in_oob || (read_enable && rd_in_oob)) begin
                            err[ERR_OOB] <= 1'b1;
                        end
                        if ((write_size != SIZE_WORD) ||
                            (read_enable && (read_size != SIZE_WORD))) begin
                            err[ERR_PROTO] <= 1'b1;
                        end
                        if (WR_LAT == 1) begin
                            state       <= WR_RESP;
                            write_ready <= READY_ONE;
                        end else begin
                            state <= WR_WAIT;
                            cnt   <= WR_CNT;
                        end
                    end else if (read_enable) begin
                        rd_idx_q <= rd_in_idx;
                        rd_oob_q <= rd_in_oob;
                        if (rd_in_oob) begin
                            err[ERR_OOB] <= 1'b1;
                        end
                        if (read_size != SIZE_WORD) begin
                            err[ERR_PROTO] <= 1'b1;
                        end
                        if (RD_LAT == 1) begin
                            state      <= RD_RESP;
                            read_ready <= READY_ONE;
                        end else begin
                            state <= RD_WAIT;
                            cnt   <= RD_CNT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt == 4'd1) begin
                        state      <= RD_RESP;
                        read_ready <= READY_ONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RD_RESP: begin
                    rd_hold <= read_data;
                    state   <= IDLE;
                end
                WR_WAIT: begin
                    if (cnt == 4'd1) begin
                        state       <= WR_RESP;
                        write_ready <= READY_ONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WR_RESP: begin
                    if (rd_pend_q) begin
                        rd_pend_q <= 1'b0;
                        if (RD_LAT == 1) begin
                            state      <= RD_RESP;
                            read_ready <= READY_ONE;
                        end else begin
                            state <= RD_WAIT;
                            cnt   <= RD_CNT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SCRATCHPAD_RESP_STATS_EN
    always_ff @(posedge mod_clk or posedge reset) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if ((state == RD_RESP) && (rd_count != 32'hFFFF_FFFF)) begin
                rd_count <= rd_count + 32'd1;
            end
            if ((state == WR_RESP) && (wr_count != 32'hFFFF_FFFF)) begin
                wr_count <= wr_count + 32'd1;
            end
            if (ram_we && (ram_waddr == '0)) begin
                $display("scratchpad_responder: rd_count=%0d wr_count=%0d", rd_count, wr_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_scratchpad_responder.sv
// tb/tb_scratchpad_responder.sv - directed vector bench for scratchpad_responder
module tb_scratchpad_responder;

    logic        mod_clk;
    logic        reset;
    logic        re1, we1, re2, we2;
    logic [63:0] raddr, rsize, waddr, wsize;
    logic [31:0] wdata;
    logic [63:0] rr1, wr1, rr2, wr2;
    logic [31:0] rd1, rd2;
    logic [1:0]  err1, err2;

    int n_checks = 0;
    int n_errs   = 0;

    scratchpad_responder dut1 (
        .mod_clk(mod_clk), .reset(reset),
        .read_enable(re1), .read_addr(raddr), .read_size(rsize),
        .write_enable(we1), .write_addr(waddr), .write_data(wdata), .write_size(wsize),
        .read_ready(rr1), .read_data(rd1), .write_ready(wr1), .err(err1)
    );

    scratchpad_responder #(.RD_LAT(1), .WR_LAT(5)) dut2 (
        .mod_clk(mod_clk), .reset(reset),
        .read_enable(re2), .read_addr(raddr), .read_size(rsize),
        .write_enable(we2), .write_addr(waddr), .write_data(wdata), .write_size(wsize),
        .read_ready(rr2), .read_data(rd2), .write_ready(wr2), .err(err2)
    );

    initial mod_clk = 1'b0;
    always #5 mod_clk = ~mod_clk;

    typedef struct {
        bit          pre_rst;
        bit          wr;
        logic [63:0] addr;
        logic [31:0] data;
        logic [63:0] size;
        logic [31:0] exp_rd;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge mod_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int which, input bit wr);
        if (which == 1) return wr ? wr1[0] : rr1[0];
        return wr ? wr2[0] : rr2[0];
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // One request; lat is the number of post-edge samples until ready (0 = timeout).
    task automatic xact(input int which, input bit wr, input logic [63:0] addr,
                        input logic [31:0] data, input logic [63:0] size,
                        output int lat, output logic [31:0] rdv);
        if (wr) begin
            waddr = addr; wdata = data; wsize = size;
        end else begin
            raddr = addr; rsize = size;
        end
        if (which == 1) begin re1 = !wr; we1 = wr; end
        else            begin re2 = !wr; we2 = wr; end
        tick();
        re1 = 1'b0; we1 = 1'b0; re2 = 1'b0; we2 = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            if (rdy(which, wr)) begin
                lat = i;
                break;
            end
            tick();
        end
        rdv = (which == 1) ? rd1 : rd2;
        tick();
        chk("ready_one_cycle", {63'd0, rdy(which, wr)}, 64'd0);
    endtask

    initial begin
        int          lat;
        int          pulses;
        logic [31:0] rdv;

        reset = 1'b1;
        re1 = 0; we1 = 0; re2 = 0; we2 = 0;
        raddr = 0; rsize = 4; waddr = 0; wsize = 4; wdata = 0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_read_ready",  rr1, 64'd0);
        chk("rst_write_ready", wr1, 64'd0);
        chk("rst_read_data",   {32'd0, rd1}, 64'd0);
        chk("rst_err",         {62'd0, err1}, 64'd0);

        vecs[0]  = '{0, 1, 64'h8,    32'h1234_5678, 64'd4, 32'h0,          2'b00};
        vecs[1]  = '{0, 0, 64'h8,    32'h0,         64'd4, 32'h1234_5678,  2'b00};
        vecs[2]  = '{0, 0, 64'hB,    32'h0,         64'd4, 32'h1234_5678,  2'b00};
        vecs[3]  = '{0, 1, 64'h3FFC, 32'hA5A5_0001, 64'd4, 32'h0,          2'b00};
        vecs[4]  = '{0, 0, 64'h3FFC, 32'h0,         64'd4, 32'hA5A5_0001,  2'b00};
        vecs[5]  = '{0, 1, 64'h0,    32'h0BAD_F00D, 64'd4, 32'h0,          2'b00};
        vecs[6]  = '{0, 0, 64'h0,    32'h0,         64'd4, 32'h0BAD_F00D,  2'b00};
        vecs[7]  = '{0, 0, 64'h4000, 32'h0,         64'd4, 32'hDEAD_BEEF,  2'b01};
        vecs[8]  = '{0, 1, 64'h4000, 32'h1111_1111, 64'd4, 32'h0,          2'b01};
        vecs[9]  = '{0, 0, 64'h0,    32'h0,         64'd4, 32'h0BAD_F00D,  2'b01};
        vecs[10] = '{1, 0, 64'h8,    32'h0,         64'd8, 32'h1234_5678,  2'b10};

        foreach (vecs[i]) begin
            if (vecs[i].pre_rst) do_reset();
            xact(1, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].size, lat, rdv);
            chk($sformatf("vec%0d_latency", i), 64'(lat), vecs[i].wr ? 64'd1 : 64'd2);
            if (!vecs[i].wr) chk($sformatf("vec%0d_read_data", i), {32'd0, rdv}, {32'd0, vecs[i].exp_rd});
            chk($sformatf("vec%0d_err", i), {62'd0, err1}, {62'd0, vecs[i].exp_err});
        end

        // Both enables together: write first, then the parked read sees it.
        do_reset();
        chk("reset_clears_read_data", {32'd0, rd1}, 64'd0);
        raddr = 64'h20; rsize = 4; waddr = 64'h20; wsize = 4; wdata = 32'd7;
        re1 = 1'b1; we1 = 1'b1;
        tick();
        re1 = 1'b0; we1 = 1'b0;
        chk("both_write_ready", wr1, 64'd1);
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (rr1[0]) begin lat = i; break; end
        end
        chk("both_read_ready_latency", 64'(lat), 64'd2);
        chk("both_read_data", {32'd0, rd1}, 64'd7);
        chk("both_err", {62'd0, err1}, 64'd0);
        tick();

        // Back-to-back read strobes: second one is dropped.
        do_reset();
        raddr = 64'h8; rsize = 4;
        re1 = 1'b1;
        tick();
        tick();
        re1 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (rr1[0]) pulses++;
            tick();
        end
        chk("dup_read_pulses", 64'(pulses), 64'd1);
        chk("dup_read_err1", {63'd0, err1[1]}, 64'd1);

        // Reset right after a read strobe kills the response.
        do_reset();
        raddr = 64'h8; rsize = 4;
        re1 = 1'b1;
        tick();
        re1 = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (rr1[0]) pulses++;
            tick();
        end
        chk("reset_mid_read_pulses", 64'(pulses), 64'd0);
        xact(1, 1'b0, 64'h8, 32'h0, 64'd4, lat, rdv);
        chk("after_reset_read_latency", 64'(lat), 64'd2);
        chk("after_reset_read_data", {32'd0, rdv}, 64'h1234_5678);
        chk("after_reset_err", {62'd0, err1}, 64'd0);

        // RD_LAT=1 / WR_LAT=5 instance.
        xact(2, 1'b1, 64'h10, 32'hCAFE_F00D, 64'd4, lat, rdv);
        chk("lat5_write_latency", 64'(lat), 64'd5);
        xact(2, 1'b0, 64'h10, 32'h0, 64'd4, lat, rdv);
        chk("lat1_read_latency", 64'(lat), 64'd1);
        chk("lat1_read_data", {32'd0, rdv}, 64'hCAFE_F00D);
        chk("lat_build_err", {62'd0, err2}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
